// File: rtl/mul64_pkg.sv
// Shared types and constants for the iterative 64x64 -> 128-bit multiplier.
// Revision: 1.0
`default_nettype none

package mul64_pkg;

  localparam int WIDTH      = 64;
  localparam int PROD_WIDTH = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FIXUP = 2'd2
  } state_t;

  // Counter must hold the value N itself, not just N-1.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int CNT_WIDTH = cnt_width(WIDTH);

endpackage

`default_nettype wire

// File: rtl/mul64_step.sv
// One shift-add iteration: accumulate |a| times the low RADIX_BITS of P, then shift right.
// Revision: 1.0
`default_nettype none

module mul64_step #(
  parameter int WIDTH      = 64,
  parameter int RADIX_BITS = 1
) (
  input  logic [2*WIDTH-1:0] p,
  input  logic [WIDTH-1:0]   mcand,
  output logic [2*WIDTH-1:0] p_next
);

  localparam int SW = WIDTH + RADIX_BITS;

  logic [SW-1:0] partial;
  logic [SW-1:0] sum;

  // Sum is at most (2^W-1)*2^R, so SW bits never overflow.
  assign partial = SW'(mcand) * SW'(p[RADIX_BITS-1:0]);
  assign sum     = SW'(p[2*WIDTH-1:WIDTH]) + partial;
  assign p_next  = {sum, p[WIDTH-1:RADIX_BITS]};

endmodule

`default_nettype wire

// File: rtl/mul64_iter.sv
// Iterative signed/unsigned multiplier with start/busy/done handshake.
// Revision: 1.0
`default_nettype none

module mul64_iter #(
  parameter int WIDTH      = mul64_pkg::WIDTH,
  parameter int RADIX_BITS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi
);

  import mul64_pkg::*;

  localparam int            N    = WIDTH / RADIX_BITS;
  localparam int            CW   = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t             state;
  state_t             state_next;
  logic [2*WIDTH-1:0] p;
  logic [2*WIDTH-1:0] p_next;
  logic [2*WIDTH-1:0] p_fix;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               neg_a;
  logic               neg_b;
  logic               neg;
  logic [CW-1:0]      cnt;

  // Negating the most negative value yields 2^(W-1) read as unsigned.
  assign neg_a = is_signed & op_a[WIDTH-1];
  assign neg_b = is_signed & op_b[WIDTH-1];
  assign mag_a = neg_a ? -op_a : op_a;
  assign mag_b = neg_b ? -op_b : op_b;
  assign p_fix = neg ? -p : p;
  assign busy  = (state != IDLE);

  mul64_step #(
    .WIDTH      (WIDTH),
    .RADIX_BITS (RADIX_BITS)
  ) u_step (
    .p      (p),
    .mcand  (mcand),
    .p_next (p_next)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = BUSY;
      BUSY:    if (cnt == LAST) state_next = FIXUP;
      FIXUP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p         <= '0;
      mcand     <= '0;
      neg       <= 1'b0;
      cnt       <= '0;
      done      <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            p     <= {{WIDTH{1'b0}}, mag_b};
            mcand <= mag_a;
            neg   <= neg_a ^ neg_b;
            cnt   <= '0;
          end
        end
        BUSY: begin
          p   <= p_next;
          cnt <= cnt + CW'(1);
        end
        FIXUP: begin
          result_lo <= p_fix[WIDTH-1:0];
          result_hi <= p_fix[2*WIDTH-1:WIDTH];
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mul64_iter.sv
// Scoreboard bench for mul64_iter: directed corner products, handshake, reset, random operands.
// Revision: 1.0
`default_nettype none

module tb_mul64_iter;

  localparam int W = 64;
  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result_lo;
  logic [W-1:0] result_hi;

  typedef struct {
    logic [2*W-1:0] prod;
    int             t0;
  } exp_t;

  exp_t           sb[$];
  int             checks = 0;
  int             failures = 0;
  int             cyc = 0;
  bit             mon_on = 1'b0;
  bit             prev_done = 1'b0;
  bit             prev_reset = 1'b0;
  logic [2*W-1:0] held = '0;

  mul64_iter dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .result_lo (result_lo),
    .result_hi (result_hi)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference: exact product of the operands read as integers, truncated to 128 bits.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
    logic [2*W-1:0] xa;
    logic [2*W-1:0] xb;
    xa = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    xb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return xa * xb;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return W'($urandom_range(0, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Monitor: pops an expectation on every done pulse; otherwise results must hold.
  always @(negedge clk) begin
    exp_t e;
    if (mon_on) begin
      if (prev_reset) held = '0;
      if (done) begin
        if (prev_done) flag("done_pulse_width");
        chk("busy_at_done", {{(2*W-1){1'b0}}, busy}, '0);
        if (sb.size() == 0) begin
          flag("unexpected_done");
        end else begin
          e = sb.pop_front();
          chk("product", {result_hi, result_lo}, e.prod);
          chk("latency", 128'(cyc - e.t0), 128'(N + 1));
          held = e.prod;
        end
      end else begin
        chk("result_hold", {result_hi, result_lo}, held);
      end
    end
    prev_done  = done;
    prev_reset = reset;
  end

  task automatic wait_idle();
    int g = 0;
    while (busy !== 1'b0 && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 300) flag("idle_timeout");
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [2*W-1:0] e);
    wait_idle();
    op_a = a; op_b = b; is_signed = s; start = 1'b1;
    @(posedge clk); #1;
    sb.push_back('{e, cyc});
    start = 1'b0;
    chk("busy_after_start", {{(2*W-1){1'b0}}, busy}, 128'd1);
    op_a = {$urandom, $urandom};
    op_b = {$urandom, $urandom};
    is_signed = 1'($urandom);
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() != 0 && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    if (sb.size() != 0) begin
      flag("drain_timeout");
      sb.delete();
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy", {{(2*W-1){1'b0}}, busy}, '0);
    chk("rst_done", {{(2*W-1){1'b0}}, done}, '0);
    chk("rst_lo", {{W{1'b0}}, result_lo}, '0);
    chk("rst_hi", {{W{1'b0}}, result_hi}, '0);
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    int           g;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_reset_outputs();
    mon_on = 1'b1;

    issue(64'd3, 64'd5, 1'b0, 128'd15);
    drain();
    issue('1, '1, 1'b0, {64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001});
    issue('1, 64'd1, 1'b1, {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF});
    issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1,
          {64'h4000_0000_0000_0000, 64'h0});
    issue(64'h8000_0000_0000_0000, 64'd1, 1'b1,
          {64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000});
    drain();

    // start held high while busy must be ignored until the done cycle.
    wait_idle();
    op_a = 64'd7; op_b = 64'd9; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    sb.push_back('{128'd63, cyc});
    op_a = 64'd2; op_b = 64'd2;
    g = 0;
    while (done !== 1'b1 && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 200) begin
      flag("done_timeout");
    end else begin
      @(posedge clk); #1;
      sb.push_back('{128'd4, cyc});
    end
    start = 1'b0;
    drain();

    // Abandon an operation mid-flight.
    a = pick(); b = pick(); s = 1'b1;
    issue(a, b, s, model(a, b, s));
    repeat (30) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    chk_reset_outputs();
    issue(64'd123456789, 64'hFFFF_FFFF_FFFF_FFF6, 1'b1, model(64'd123456789, 64'hFFFF_FFFF_FFFF_FFF6, 1'b1));
    drain();

    // reset beats a simultaneous start.
    op_a = 64'd11; op_b = 64'd13; is_signed = 1'b0;
    start = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; reset = 1'b0;
    chk_reset_outputs();
    repeat (N + 5) @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      a = pick(); b = pick(); s = 1'($urandom_range(0, 1));
      issue(a, b, s, model(a, b, s));
    end
    drain();
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
